// File: rtl/multdivid_iter_unit.sv
// multdivid_iter_unit: iterative radix-2 multiply/divide engine, one result bit per cycle.
// The latency is fixed for any operand values. Results go out as a HI/LO pair.
// Build option: define MULTDIVID_SIGNED_EN to honour op_signed (two's-complement operations).
// In the default build every operation is unsigned. The PREP and FIXUP states remain in both
// builds, so the latency does not change between them.
module multdivid_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_div,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH+1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               is_signed;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_raw;
    logic [WIDTH-1:0]   divisor;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;          // upper: partial product / remainder, lower: multiplier / quotient
    logic               neg_lo;
    logic               neg_hi;
    logic               zero_div;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               unused_inputs;

`ifdef MULTDIVID_SIGNED_EN
    assign unused_inputs = ^operand_b[WIDTH+1:WIDTH];
`else
    assign unused_inputs = ^{operand_b[WIDTH+1:WIDTH], op_signed};
`endif

    // Operand magnitudes, the shift-add / trial-subtract step, and the final sign correction
    always_comb begin
`ifdef MULTDIVID_SIGNED_EN
        a_neg = is_signed & a_raw[WIDTH-1];
        b_neg = is_signed & b_raw[WIDTH-1];
        a_mag = a_neg ? -a_raw : a_raw;
        b_mag = b_neg ? -b_raw : b_raw;
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = a_raw;
        b_mag = b_raw;
`endif
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
`ifdef MULTDIVID_SIGNED_EN
        prod_fix = neg_lo ? -acc : acc;
        q_fix    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
        prod_fix = acc;
        q_fix    = acc[WIDTH-1:0];
        r_fix    = acc[2*WIDTH-1:WIDTH];
`endif
    end

    // Sequencer: IDLE -> PREP -> ITER (WIDTH steps) -> FIXUP; results are registered on leaving FIXUP
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            is_signed   <= 1'b0;
            a_raw       <= '0;
            b_raw       <= '0;
            divisor     <= '0;
            acc         <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op_div;
`ifdef MULTDIVID_SIGNED_EN
                        is_signed <= op_signed;
`else
                        is_signed <= 1'b0;
`endif
                        a_raw  <= operand_a;
                        b_raw  <= operand_b[WIDTH-1:0];
                        busy   <= 1'b1;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    divisor  <= b_mag;
                    acc      <= {{WIDTH{1'b0}}, a_mag};
                    zero_div <= is_div & (b_raw == '0);
                    neg_lo   <= a_neg ^ b_neg;
                    neg_hi   <= is_div & a_neg;
                    count    <= CW'(WIDTH - 1);
                    state    <= S_ITER;
                end
                S_ITER: begin
                    if (is_div) begin
                        if (!trial[WIDTH])
                            acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {add_sum, acc[WIDTH-1:1]};
                    end
                    count <= count - 1'b1;
                    if (count == '0)
                        state <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (zero_div) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi          <= r_fix;
                        lo          <= q_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        {hi, lo}    <= prod_fix;
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdivid_iter_unit.sv
// Testbench for multdivid_iter_unit. It runs directed cases first, then randomized operations.
// The expected results come from 64-bit integer arithmetic.
module tb_multdivid_iter_unit;

    localparam int W = 32;
`ifdef MULTDIVID_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           op_div;
    logic           op_signed;
    logic [W-1:0]   operand_a;
    logic [W+1:0]   operand_b;
    logic           busy;
    logic           done;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           div_by_zero;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [W-1:0]   prev_hi = '0;
    logic [W-1:0]   prev_lo = '0;

    multdivid_iter_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
        .op_signed   (op_signed),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit div, input bit sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] ehi,
                                  output logic [W-1:0] elo, output bit edbz);
        longint       sa;
        longint       sb;
        longint       r;
        logic [63:0]  up;
        bit           s;
        s    = SIGNED_EN && sgn;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        edbz = 1'b0;
        if (div) begin
            if (b == '0) begin
                elo  = '1;
                ehi  = a;
                edbz = 1'b1;
            end else if (s) begin
                r   = sa / sb;
                elo = r[W-1:0];
                r   = sa % sb;
                ehi = r[W-1:0];
            end else begin
                elo = a / b;
                ehi = a % b;
            end
        end else begin
            if (s) begin
                r   = sa * sb;
                ehi = r[63:32];
                elo = r[31:0];
            end else begin
                up  = 64'(a) * 64'(b);
                ehi = up[63:32];
                elo = up[31:0];
            end
        end
    endfunction

    // Drives one operation starting at the current time, then follows it to its done pulse.
    // If poke_at > 0, a stray start is issued while busy; the DUT must ignore it.
    task automatic do_op(input string name, input bit div, input bit sgn, input logic [W-1:0] a,
                         input logic [W+1:0] b, input int poke_at);
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        bit           edbz;
        int           cycles;
        model(div, sgn, a, b[W-1:0], ehi, elo, edbz);
        start     = 1'b1;
        op_div    = div;
        op_signed = sgn;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_div    = ~div;
        op_signed = ~sgn;
        operand_a = $urandom;
        operand_b = {2'($urandom_range(3, 0)), $urandom};
        check({name, "_busy_start"}, 64'(busy), 64'd1);
        cycles = 0;
        while (!done && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == poke_at) begin
                start     = 1'b1;
                op_div    = ~div;
                operand_a = $urandom;
                operand_b = {2'b00, $urandom};
            end else if (cycles == poke_at + 1) begin
                start = 1'b0;
            end
            if (cycles == 5) begin
                check({name, "_busy_mid"}, 64'(busy), 64'd1);
                check({name, "_hold"}, {hi, lo}, {prev_hi, prev_lo});
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(cycles), 64'(W + 2));
        check({name, "_busy_done"}, 64'(busy), 64'd0);
        check({name, "_hilo"}, {hi, lo}, {ehi, elo});
        check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    initial begin
        int           saw_done;
        logic [W-1:0] ra;
        logic [W+1:0] rb;
        reset     = 1'b1;
        start     = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 34'h0_FFFF_FFFF, 0);
        do_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 34'h0_0000_0002, 0);
        do_op("div_zero", 1'b1, 1'b0, 32'h0000_1234, 34'h3_0000_0000, 0);
        do_op("after_dbz", 1'b1, 1'b0, 32'd100, 34'd9, 0);
        do_op("smul_m3_5", 1'b0, 1'b1, 32'hFFFF_FFFD, 34'd5, 10);
        do_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 34'h0_FFFF_FFFF, 0);
        do_op("sdiv_zero", 1'b1, 1'b1, 32'hFFFF_FF00, 34'd0, 0);

        // Abort a divide part-way with reset
        start     = 1'b1;
        op_div    = 1'b1;
        op_signed = 1'b0;
        operand_a = 32'd1000;
        operand_b = 34'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done++;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        do_op("post_abort", 1'b1, 1'b0, 32'd1000, 34'd3, 0);

        // Back-to-back: the second start lands in the done cycle of the first operation
        do_op("b2b_mul", 1'b0, 1'b0, 32'd6, 34'd7, 0);
        do_op("b2b_div", 1'b1, 1'b0, 32'd100, 34'd7, 0);

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
            ra = $urandom;
            rb = {2'($urandom_range(3, 0)), $urandom};
            case ($urandom_range(5, 0))
                0: rb[W-1:0] = '0;
                1: rb[W-1:0] = W'($urandom_range(15, 1));
                2: ra = W'($urandom_range(255, 0));
                3: rb[W-1:0] = ~W'($urandom_range(3, 0));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
